// File: rtl/decode_pkg.sv
// Shared constants for the decode stage: opcode values, instruction type
// encodings, bundle field widths and small classification helpers.
package decode_pkg;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 7;
  localparam int FUNCT3_W = 3;
  localparam int FUNCT7_W = 7;
  localparam int TYPE_W   = 3;

  localparam logic [OPCODE_W-1:0] OP_REG    = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;

  typedef enum logic [TYPE_W-1:0] {
    TYPE_R       = 3'd0,
    TYPE_I       = 3'd1,
    TYPE_S       = 3'd2,
    TYPE_B       = 3'd3,
    TYPE_U       = 3'd4,
    TYPE_J       = 3'd5,
    TYPE_ILLEGAL = 3'd7
  } instr_type_e;

  // Any opcode outside the RV32I base set, including compressed ones, is illegal.
  function automatic instr_type_e decode_type(input logic [OPCODE_W-1:0] opcode);
    instr_type_e t;
    case (opcode)
      OP_REG:                    t = TYPE_R;
      OP_LOAD, OP_IMM, OP_JALR:  t = TYPE_I;
      OP_STORE:                  t = TYPE_S;
      OP_BRANCH:                 t = TYPE_B;
      OP_LUI, OP_AUIPC:          t = TYPE_U;
      OP_JAL:                    t = TYPE_J;
      default:                   t = TYPE_ILLEGAL;
    endcase
    return t;
  endfunction

  function automatic logic uses_rs1(input instr_type_e t);
    return (t == TYPE_R) || (t == TYPE_I) || (t == TYPE_S) || (t == TYPE_B);
  endfunction

  function automatic logic uses_rs2(input instr_type_e t);
    return (t == TYPE_R) || (t == TYPE_S) || (t == TYPE_B);
  endfunction

  function automatic logic writes_rd(input instr_type_e t);
    return (t == TYPE_R) || (t == TYPE_I) || (t == TYPE_U) || (t == TYPE_J);
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; the result is sign-extended to
// WORD_SIZE. Opcode bits are not needed, so only instr[31:7] is taken.
module imm_gen
  import decode_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [INSTR_W-1:7]   i_instr,
  input  instr_type_e          i_type,
  output logic [WORD_SIZE-1:0] o_imm
);

  logic [31:0] w_imm32;

  always_comb begin
    w_imm32 = '0;
    case (i_type)
      TYPE_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      TYPE_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      TYPE_B: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
      TYPE_U: w_imm32 = {i_instr[31:12], 12'b0};
      TYPE_J: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                         i_instr[20], i_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign o_imm = WORD_SIZE'($signed(w_imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: one registered output bundle with valid/ready handshake
// and a register scoreboard that stalls on read-after-write hazards.
module decode_stage
  import decode_pkg::*;
#(
  parameter int WORD_SIZE     = 32,
  parameter int REG_ADDR_W    = 5,
  parameter int SCOREBOARD_EN = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    in_instr,
  input  logic [WORD_SIZE-1:0]  in_pc,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_SIZE-1:0]  out_pc,
  output logic [REG_ADDR_W-1:0] out_rs1,
  output logic [REG_ADDR_W-1:0] out_rs2,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [WORD_SIZE-1:0]  out_imm,
  output logic [FUNCT3_W-1:0]   out_funct3,
  output logic [FUNCT7_W-1:0]   out_funct7,
  output logic [TYPE_W-1:0]     out_type,
  output logic                  out_we,
  output logic                  out_illegal
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  instr_type_e           w_type;
  logic [REG_ADDR_W-1:0] w_rs1;
  logic [REG_ADDR_W-1:0] w_rs2;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [WORD_SIZE-1:0]  w_imm;
  logic                  w_we;
  logic                  w_rs1_busy;
  logic                  w_rs2_busy;
  logic                  w_hazard;
  logic                  w_accept;
  logic [NUM_REGS-1:0]   r_busy;

  assign w_type = decode_type(in_instr[OPCODE_W-1:0]);
  assign w_rs1  = REG_ADDR_W'(in_instr[19:15]);
  assign w_rs2  = REG_ADDR_W'(in_instr[24:20]);
  assign w_rd   = REG_ADDR_W'(in_instr[11:7]);
  assign w_we   = writes_rd(w_type) && (w_rd != '0);

  imm_gen #(
    .WORD_SIZE(WORD_SIZE)
  ) u_imm_gen (
    .i_instr(in_instr[INSTR_W-1:7]),
    .i_type (w_type),
    .o_imm  (w_imm)
  );

  // A writeback retiring in the same cycle already resolves the dependency.
  assign w_rs1_busy = (w_rs1 != '0) && r_busy[w_rs1] && !(wb_valid && (wb_addr == w_rs1));
  assign w_rs2_busy = (w_rs2 != '0) && r_busy[w_rs2] && !(wb_valid && (wb_addr == w_rs2));
  assign w_hazard   = (SCOREBOARD_EN != 0) &&
                      ((uses_rs1(w_type) && w_rs1_busy) || (uses_rs2(w_type) && w_rs2_busy));

  assign in_ready = !reset && (!out_valid || out_ready) && !w_hazard;
  assign w_accept = in_valid && in_ready;

  // Setting a busy bit takes priority over a same-cycle writeback clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_accept && w_we && (w_rd == REG_ADDR_W'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (wb_valid && (wb_addr == REG_ADDR_W'(i))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_imm     <= '0;
      out_funct3  <= '0;
      out_funct7  <= '0;
      out_type    <= '0;
      out_we      <= 1'b0;
      out_illegal <= 1'b0;
    end else if (w_accept) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_rs1     <= w_rs1;
      out_rs2     <= w_rs2;
      out_rd      <= w_rd;
      out_imm     <= w_imm;
      out_funct3  <= in_instr[14:12];
      out_funct7  <= in_instr[31:25];
      out_type    <= w_type;
      out_we      <= w_we;
      out_illegal <= (w_type == TYPE_ILLEGAL);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] inInstr = '0;
  logic [31:0] inPc = '0;
  logic        wbValid = 1'b0;
  logic [4:0]  wbAddr = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [31:0] outPc;
  logic [4:0]  outRs1, outRs2, outRd;
  logic [31:0] outImm;
  logic [2:0]  outFunct3;
  logic [6:0]  outFunct7;
  logic [2:0]  outType;
  logic        outWe, outIllegal;

  int tests = 0;
  int fails = 0;

  decode_stage dut (
    .clock(clock), .reset(reset),
    .in_valid(inValid), .in_ready(inReady), .in_instr(inInstr), .in_pc(inPc),
    .wb_valid(wbValid), .wb_addr(wbAddr),
    .out_valid(outValid), .out_ready(outReady), .out_pc(outPc),
    .out_rs1(outRs1), .out_rs2(outRs2), .out_rd(outRd), .out_imm(outImm),
    .out_funct3(outFunct3), .out_funct7(outFunct7), .out_type(outType),
    .out_we(outWe), .out_illegal(outIllegal)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit [2:0]  typ;
    bit [31:0] imm;
    bit [4:0]  rd, rs1, rs2;
    bit [2:0]  f3;
    bit [6:0]  f7;
    bit        we, ill;
    bit [31:0] pc;
  } bundle_t;

  bit      mBusy [32];
  bit      mValid;
  bundle_t mOut;

  function automatic bit [2:0] typeOf(bit [31:0] ins);
    case (ins[6:0])
      7'h33:               return 3'd0;
      7'h03, 7'h13, 7'h67: return 3'd1;
      7'h23:               return 3'd2;
      7'h63:               return 3'd3;
      7'h37, 7'h17:        return 3'd4;
      7'h6F:               return 3'd5;
      default:             return 3'd7;
    endcase
  endfunction

  // Immediates built with signed shifts rather than bit concatenation.
  function automatic bundle_t modelDecode(bit [31:0] ins, bit [31:0] pc);
    bundle_t b;
    int s;
    s = int'(ins);
    b.typ = typeOf(ins);
    b.rd = ins[11:7]; b.rs1 = ins[19:15]; b.rs2 = ins[24:20];
    b.f3 = ins[14:12]; b.f7 = ins[31:25]; b.pc = pc;
    case (b.typ)
      3'd1: b.imm = 32'(s >>> 20);
      3'd2: b.imm = 32'((s >>> 25) * 32 + int'(ins[11:7]));
      3'd3: b.imm = 32'((s >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2);
      3'd4: b.imm = ins & 32'hFFFFF000;
      3'd5: b.imm = 32'((s >>> 31) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2);
      default: b.imm = 32'd0;
    endcase
    b.we = (b.typ == 3'd0 || b.typ == 3'd1 || b.typ == 3'd4 || b.typ == 3'd5) && (b.rd != 5'd0);
    b.ill = (b.typ == 3'd7);
    return b;
  endfunction

  function automatic bit regBusy(bit [4:0] r);
    return (r != 5'd0) && mBusy[r] && !(wbValid && wbAddr == r);
  endfunction

  function automatic bit modelReady();
    bit [2:0] t;
    bit hz;
    t = typeOf(inInstr);
    hz = ((t == 3'd0 || t == 3'd1 || t == 3'd2 || t == 3'd3) && regBusy(inInstr[19:15])) ||
         ((t == 3'd0 || t == 3'd2 || t == 3'd3) && regBusy(inInstr[24:20]));
    return !reset && (!mValid || outReady) && !hz;
  endfunction

  function automatic bit [31:0] modelBusyWord();
    bit [31:0] w;
    for (int i = 0; i < 32; i++) w[i] = mBusy[i];
    return w;
  endfunction

  task automatic modelReset();
    mValid = 1'b0;
    mOut = '{default: 0};
    for (int i = 0; i < 32; i++) mBusy[i] = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    check("out_valid",   32'(outValid),   32'(mValid));
    check("out_pc",      outPc,           mOut.pc);
    check("out_rs1",     32'(outRs1),     32'(mOut.rs1));
    check("out_rs2",     32'(outRs2),     32'(mOut.rs2));
    check("out_rd",      32'(outRd),      32'(mOut.rd));
    check("out_imm",     outImm,          mOut.imm);
    check("out_funct3",  32'(outFunct3),  32'(mOut.f3));
    check("out_funct7",  32'(outFunct7),  32'(mOut.f7));
    check("out_type",    32'(outType),    32'(mOut.typ));
    check("out_we",      32'(outWe),      32'(mOut.we));
    check("out_illegal", 32'(outIllegal), 32'(mOut.ill));
    check("busy",        32'(dut.r_busy), modelBusyWord());
  endtask

  // One clock: check in_ready, advance the model across the edge, compare outputs.
  task automatic step();
    bit acc, wbv;
    bit [4:0] wba;
    bundle_t nb;
    #1;
    check("in_ready", 32'(inReady), 32'(modelReady()));
    acc = inValid && modelReady();
    nb  = modelDecode(inInstr, inPc);
    wbv = wbValid;
    wba = wbAddr;
    @(posedge clock);
    if (reset) begin
      modelReset();
    end else begin
      if (wbv) mBusy[wba] = 1'b0;
      if (acc && nb.we) mBusy[nb.rd] = 1'b1;
      if (acc) begin
        mValid = 1'b1;
        mOut = nb;
      end else if (outReady) begin
        mValid = 1'b0;
      end
    end
    #1;
    checkOutput();
  endtask

  function automatic bit [31:0] randInstr();
    bit [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 9);
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    w[11:7]  = 5'($urandom_range(0, 7));
    case (k)
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h03;
      2: w[6:0] = 7'h13;
      3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h23;
      5: w[6:0] = 7'h63;
      6: w[6:0] = 7'h37;
      7: w[6:0] = 7'h17;
      8: w[6:0] = 7'h6F;
      default: ;
    endcase
    return w;
  endfunction

  task automatic applyStimulus();
    inValid  = ($urandom_range(0, 9) < 7);
    inInstr  = randInstr();
    inPc     = $urandom & 32'hFFFFFFFC;
    outReady = ($urandom_range(0, 3) != 0);
    wbValid  = ($urandom_range(0, 9) < 3);
    wbAddr   = 5'($urandom_range(0, 7));
  endtask

  initial begin
    reset = 1'b1;
    modelReset();
    step();
    step();
    check("rst_in_ready", 32'(inReady), 32'd0);
    reset = 1'b0;
    outReady = 1'b1;

    // addi x5,x0,-1
    inValid = 1'b1; inInstr = 32'hFFF00293; inPc = 32'h100;
    step();
    check("addi_valid", 32'(outValid), 32'd1);
    check("addi_type",  32'(outType),  32'd1);
    check("addi_imm",   outImm,        32'hFFFFFFFF);
    check("addi_rd",    32'(outRd),    32'd5);
    check("addi_we",    32'(outWe),    32'd1);
    check("addi_busy5", 32'(dut.r_busy[5]), 32'd1);

    // add x6,x5,x1 stalls until x5 retires
    inInstr = 32'h00128333; inPc = 32'h104;
    #1 check("add_stall", 32'(inReady), 32'd0);
    step();
    step();
    wbValid = 1'b1; wbAddr = 5'd5;
    #1 check("add_wb_ready", 32'(inReady), 32'd1);
    step();
    wbValid = 1'b0;
    check("add_rd",  32'(outRd),  32'd6);
    check("add_rs1", 32'(outRs1), 32'd5);
    check("add_rs2", 32'(outRs2), 32'd1);
    check("add_pc",  outPc,       32'h104);

    // beq -4
    inInstr = 32'hFE000EE3; inPc = 32'h108;
    step();
    check("beq_type", 32'(outType), 32'd3);
    check("beq_imm",  outImm,       32'hFFFFFFFC);
    check("beq_we",   32'(outWe),   32'd0);

    // Backpressure holds the bundle for three cycles
    outReady = 1'b0;
    inInstr = 32'h00100393; inPc = 32'h10C;
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_ready", 32'(inReady), 32'd0);
      step();
      check("hold_imm", outImm, 32'hFFFFFFFC);
      check("hold_pc",  outPc,  32'h108);
    end
    outReady = 1'b1;
    #1 check("release_ready", 32'(inReady), 32'd1);
    step();
    check("release_rd", 32'(outRd), 32'd7);
    check("release_pc", outPc,      32'h10C);

    // All-zero word is illegal and leaves the scoreboard alone
    inInstr = 32'h0; inPc = 32'h110;
    step();
    check("ill_flag", 32'(outIllegal), 32'd1);
    check("ill_type", 32'(outType),    32'd7);
    check("ill_we",   32'(outWe),      32'd0);
    check("ill_busy", 32'(dut.r_busy), 32'h000000C0);

    // Asynchronous reset in the middle of a cycle
    inInstr = 32'h00200413;
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(outValid),  32'd0);
    check("arst_busy",  32'(dut.r_busy), 32'd0);
    check("arst_ready", 32'(inReady),   32'd0);
    modelReset();
    step();
    reset = 1'b0;
    inValid = 1'b0;
    step();

    for (int n = 0; n < 3000; n++) begin
      applyStimulus();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, datapath width (min 32); immediates sign-extended to WORD_SIZE.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, register index width.
REQ-003 SHALL have parameter SCOREBOARD_EN, default 1; 0 disables hazard stalls.
REQ-004 SHALL have ports, one clock, reset asynchronous active-high:
  clock  in  1  rising-edge clock
  reset  in  1  async active-high reset
  in_valid  in  1  fetch offers instruction
  in_ready  out  1  stage accepts this cycle
  in_instr  in  32  RV32 instruction word
  in_pc  in  WORD_SIZE  instruction address
  wb_valid  in  1  writeback retires a register write
  wb_addr  in  REG_ADDR_W  retired destination register
  out_valid  out  1  decoded bundle valid
  out_ready  in  1  execute accepts bundle
  out_pc  out  WORD_SIZE  registered pc
  out_rs1, out_rs2, out_rd  out  REG_ADDR_W each  register indices (rs to register-file read ports)
  out_imm  out  WORD_SIZE  sign-extended immediate
  out_funct3  out  3;  out_funct7  out  7  function fields
  out_type  out  3  R=0 I=1 S=2 B=3 U=4 J=5 ILLEGAL=7
  out_we  out  1  instruction writes rd
  out_illegal  out  1  unrecognised encoding

Function
REQ-005 SHALL decode opcodes: 0110011 R; 0000011/0010011/1100111 I; 0100011 S; 1100011 B; 0110111/0010111 U; 1101111 J; all others incl. opcode[1:0]!=11 ILLEGAL.
REQ-006 SHALL form immediates per RV32I (I: [31:20]; S: [31:25],[11:7]; B: [31],[7],[30:25],[11:8],0; U: [31:12]<<12; J: [31],[19:12],[20],[30:21],0); R and ILLEGAL give 0.
REQ-007 SHALL set out_we=1 for R,I,U,J with rd!=0, else 0.
REQ-008 SHALL register one bundle: accept when in_valid&&in_ready; bundle appears on outputs next cycle (latency 1).
REQ-009 SHALL drive in_ready = (!out_valid || out_ready) && !hazard, combinationally.
REQ-010 SHALL hold all out_* stable while out_valid&&!out_ready.
REQ-011 SHALL clear out_valid after out_ready when no new accept occurs that cycle; back-to-back accepts give full throughput.
REQ-012 SHALL keep busy[2**REG_ADDR_W] scoreboard: set busy[rd] on accept with out_we; clear busy[wb_addr] on wb_valid.
REQ-013 SHALL assert hazard when a used source (R,S,B: rs1,rs2; I: rs1; U,J: none) is busy and not cleared by wb this cycle; x0 never busy.
REQ-014 SHALL let set win when the same register is set and cleared in one cycle.
REQ-015 SHALL pass ILLEGAL instructions through with out_illegal=1, out_we=0, no scoreboard update.
REQ-016 SHALL force hazard=0 when SCOREBOARD_EN=0.

Reset
REQ-017 SHALL on reset, asynchronously: out_valid=0, all out_* fields 0, busy all 0; in-flight bundle discarded.
REQ-018 SHALL drive in_ready=0 while reset is asserted.

Structure
REQ-019 SHALL place opcode constants, type encodings and bundle width constants in shared package decode_pkg.
REQ-020 SHALL implement immediate generation as combinational sub-module imm_gen (instr, type -> imm).
REQ-021 SHALL leave register file external; decode_stage only supplies indices.

Verification
REQ-022 addi x5,x0,-1 (0xFFF00293) accepted, out_ready=1 -> next cycle out_type=1, out_imm=0xFFFFFFFF, out_rd=5, out_we=1, busy[5]=1.
REQ-023 then add x6,x5,x1 offered -> in_ready=0 until wb_valid,wb_addr=5; accepted same cycle wb asserts.
REQ-024 beq offset -4 (0xFE000EE3) -> out_type=3, out_imm=0xFFFFFFFC, out_we=0.
REQ-025 out_ready=0 for 3 cycles with bundle held -> outputs unchanged, in_ready=0; release -> next accept next cycle.
REQ-026 instruction 0x00000000 -> out_illegal=1, out_type=7, no busy bit set; reset mid-stream -> out_valid=0 immediately, busy cleared.
